// File: rtl/gpu_warp_pkg.sv
// Shared warp-level definitions for the mask path: sizes, sequencer state
// encoding and the popcount used by both the mask stage and the sequencer.
package gpu_warp_pkg;

   localparam int WARP_SIZE     = 32;
   localparam int LANE_ID_WIDTH = 5;
   localparam int CNT_WIDTH     = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seqState_e;

   // CNT_WIDTH holds WARP_SIZE itself, so an all-ones mask counts without wrap
   function automatic logic [CNT_WIDTH-1:0] popcount(input logic [WARP_SIZE-1:0] mask);
      logic [CNT_WIDTH-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < WARP_SIZE; i++) begin
         cnt = cnt + CNT_WIDTH'(mask[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Combinational find-first-set: index of the lowest set bit plus a nonzero flag.
module lane_prio_enc #(
   parameter int WIDTH     = 32,
   parameter int IDX_WIDTH = 5
) (
   input  logic [WIDTH-1:0]     vec_i,
   output logic [IDX_WIDTH-1:0] idx_o,
   output logic                 nonzero_o
);

   // Scanning from the top down lets the lowest set bit win
   always_comb begin
      idx_o     = '0;
      nonzero_o = |vec_i;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/warp_lane_sequencer.sv
// Serializes an accepted warp active mask into one lane index per cycle,
// lowest lane first, with a zero-bubble hand-over to the next mask.
module warp_lane_sequencer
   import gpu_warp_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mask_valid,
   output logic                     mask_ready,
   input  logic [WARP_SIZE-1:0]     mask_in,
   output logic                     lane_valid,
   input  logic                     lane_ready,
   output logic [LANE_ID_WIDTH-1:0] lane_id,
   output logic                     lane_last,
   output logic [CNT_WIDTH-1:0]     remaining,
   output logic                     busy
);

   seqState_e              state_q, state_d;
   logic [WARP_SIZE-1:0]   remMask_q, remMask_d;
   logic [CNT_WIDTH-1:0]   remCnt_q, remCnt_d;
   logic [LANE_ID_WIDTH-1:0] firstLane;
   logic                   anyLeft;
   logic                   laneHandshake;
   logic                   maskAccept;

   lane_prio_enc #(
      .WIDTH     (WARP_SIZE),
      .IDX_WIDTH (LANE_ID_WIDTH)
   ) u_prioEnc (
      .vec_i     (remMask_q),
      .idx_o     (firstLane),
      .nonzero_o (anyLeft)
   );

   // Lane-side outputs come only from registers; only mask_ready looks at lane_ready
   always_comb begin
      lane_valid    = (state_q == ISSUE) && anyLeft;
      lane_id       = lane_valid ? firstLane : '0;
      lane_last     = lane_valid && (remCnt_q == CNT_WIDTH'(1));
      remaining     = lane_valid ? remCnt_q : '0;
      busy          = (state_q == ISSUE);
      laneHandshake = lane_valid && lane_ready;
      mask_ready    = (state_q == IDLE) || (laneHandshake && lane_last);
      maskAccept    = mask_valid && mask_ready;
   end

   // A new mask can only land when the current one is empty, so loading it
   // simply overrides the retire of the final lane
   always_comb begin
      state_d   = state_q;
      remMask_d = remMask_q;
      remCnt_d  = remCnt_q;
      if (laneHandshake) begin
         remMask_d = remMask_q & ~(WARP_SIZE'(1) << lane_id);
         remCnt_d  = remCnt_q - CNT_WIDTH'(1);
         if (lane_last) begin
            state_d = IDLE;
         end
      end
      if (maskAccept) begin
         if (mask_in != '0) begin
            state_d   = ISSUE;
            remMask_d = mask_in;
            remCnt_d  = popcount(mask_in);
         end else begin
            state_d   = IDLE;
            remMask_d = '0;
            remCnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         remMask_q <= '0;
         remCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         remMask_q <= remMask_d;
         remCnt_q  <= remCnt_d;
      end
   end

endmodule

// File: tb/tb_warp_lane_sequencer.sv
// Self-checking bench for warp_lane_sequencer: directed scenarios followed by
// random traffic, all compared against a queue-of-pending-lanes model.
module tb_warp_lane_sequencer;

   logic        clk;
   logic        rst;
   logic        maskValid;
   logic        maskReady;
   logic [31:0] maskIn;
   logic        laneValid;
   logic        laneReady;
   logic [4:0]  laneId;
   logic        laneLast;
   logic [5:0]  remaining;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Pending lanes of the mask in flight, in emission order
   int lanes[$];

   warp_lane_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .mask_valid (maskValid),
      .mask_ready (maskReady),
      .mask_in    (maskIn),
      .lane_valid (laneValid),
      .lane_ready (laneReady),
      .lane_id    (laneId),
      .lane_last  (laneLast),
      .remaining  (remaining),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs follow directly from what is still pending
   task automatic checkOutput();
      int n;
      n = lanes.size();
      chk("mask_ready", 32'(maskReady), 32'((n == 0) || (laneReady && n == 1)));
      chk("lane_valid", 32'(laneValid), 32'(n > 0));
      chk("lane_id",    32'(laneId),    (n > 0) ? 32'(lanes[0]) : 32'd0);
      chk("lane_last",  32'(laneLast),  32'(n == 1));
      chk("remaining",  32'(remaining), 32'(n));
      chk("busy",       32'(busy),      32'(n > 0));
   endtask

   // Drive one cycle of inputs, check, then advance the model across the edge
   task automatic applyStimulus(input logic r, input logic mv, input logic [31:0] mi,
                                input logic lr, input bit doCheck);
      bit hs;
      bit rdy;
      rst       = r;
      maskValid = mv;
      maskIn    = mi;
      laneReady = lr;
      #1;
      if (doCheck) checkOutput();
      hs  = (lanes.size() > 0) && lr;
      rdy = (lanes.size() == 0) || (lr && lanes.size() == 1);
      @(posedge clk);
      if (r) begin
         lanes.delete();
      end else begin
         if (hs) void'(lanes.pop_front());
         if (mv && rdy) begin
            lanes.delete();
            for (int i = 0; i < 32; i++) begin
               if (mi[i]) lanes.push_back(i);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rndMask;
      rst = 1'b1; maskValid = 1'b0; maskIn = '0; laneReady = 1'b0;

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] sparse mask");
      applyStimulus(1'b0, 1'b1, 32'h8000_0012, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] backpressure");
      applyStimulus(1'b0, 1'b1, 32'h0000_0005, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] back-to-back");
      applyStimulus(1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'hC000_0000, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] zero mask then full mask");
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      for (int i = 0; i < 33; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] mid-operation reset");
      applyStimulus(1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       rndMask = 32'h0;
            1:       rndMask = $urandom;
            2:       rndMask = $urandom & $urandom & $urandom;
            default: rndMask = 32'h1 << $urandom_range(0, 31);
         endcase
         applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                       rndMask, ($urandom_range(0, 9) < 7), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/warp_lane_sequencer.md
# warp_lane_sequencer

Consumer end of the warp active-mask path: accepts a registered warp active mask via a valid/ready handshake and serializes it into one active lane index per cycle, lowest lane first, for the per-lane issue/writeback stage. It sits directly downstream of the mask pipeline register and popcount stage. It tracks the remaining-lane count so downstream logic can see how many lanes are still pending.

## Interface
- WARP_SIZE, 32, lanes per warp
- LANE_ID_WIDTH, 5, width of lane index (clog2(WARP_SIZE))
- CNT_WIDTH, 6, width of lane counts (clog2(WARP_SIZE)+1)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- mask_valid  input  1  mask_in is offered
- mask_ready  output  1  block accepts mask this cycle
- mask_in  input  WARP_SIZE  warp active mask, bit i = lane i active
- lane_valid  output  1  lane_id is valid
- lane_ready  input  1  downstream accepts lane_id
- lane_id  output  LANE_ID_WIDTH  index of current active lane
- lane_last  output  1  lane_id is the final active lane of this mask
- remaining  output  CNT_WIDTH  active lanes not yet handed off, including the current one
- busy  output  1  state is ISSUE

## Operation
- State: 2-state FSM, IDLE and ISSUE. Registers: rem_mask[WARP_SIZE], rem_cnt[CNT_WIDTH].
- Reset puts state in IDLE, with rem_mask=0 and rem_cnt=0. All outputs then read 0, except mask_ready, which is 1.
- mask_ready = (state==IDLE) | (lane_valid & lane_ready & lane_last).
- Accept = mask_valid & mask_ready.
- On accept with mask_in≠0:
  - rem_mask ← mask_in; rem_cnt ← popcount(mask_in); state ← ISSUE.
- On accept with mask_in==0:
  - The mask is consumed and dropped. State becomes or stays IDLE, rem_mask=0, and no lane is emitted.
- In ISSUE:
  - lane_valid=1.
  - lane_id = index of the lowest set bit of rem_mask.
  - lane_last = (rem_cnt==1).
  - remaining = rem_cnt.
- On handshake (lane_valid & lane_ready):
  - Clear bit lane_id in rem_mask and decrement rem_cnt.
  - If lane_last, go to IDLE, unless an accept happens in the same cycle, in which case the new mask is loaded (rule above).
- When lane_valid=1 and lane_ready=0, lane_id, lane_last and remaining hold stable. They must not change until the handshake.
- Lanes are emitted in strictly ascending index order. Each set bit is emitted exactly once.
- Arithmetic: popcount is WARP_SIZE-bit into CNT_WIDTH, with no overflow (an all-ones mask gives 32). The decrement never underflows, because a handshake only occurs with rem_cnt≥1.
- In IDLE: lane_valid=0, lane_id=0, lane_last=0, remaining=0.
- rst asserted mid-ISSUE: the next cycle is IDLE. The pending lanes are discarded, with no partial output.

## Timing
- Accept at edge N gives lane_valid=1 after edge N (cycle N+1) with the first lane. Latency is 1 cycle.
- Throughput is one lane per cycle when lane_ready=1.
- A mask with k active lanes occupies k cycles.
- Back-to-back masks have zero bubble: a new mask is accepted in the cycle of the last lane's handshake.
- mask_ready depends combinationally on lane_ready. lane_valid/lane_id/lane_last do not depend combinationally on any input (they are derived from registers only).
- A zero mask accepted in IDLE costs one cycle. In the following cycle mask_ready is still 1.

## Structure
- Shared package gpu_warp_pkg holds:
  - WARP_SIZE, LANE_ID_WIDTH, CNT_WIDTH defaults;
  - the state encoding (IDLE=0, ISSUE=1);
  - a popcount function shared with the upstream mask stage.
- Sub-module lane_prio_enc: parameterized find-first-set (WARP_SIZE in, LANE_ID_WIDTH index out plus a nonzero flag). It is purely combinational and reusable by the divergence stack.

## Test plan
- Reset: hold rst 2 cycles with mask_valid=1, mask_in=32'hFFFF_FFFF. Required: no accept, then IDLE with mask_ready=1, lane_valid=0, remaining=0.
- Sparse mask, lane_ready=1:
  - Stimulus: mask_in=32'h8000_0012.
  - Required: lane_ids 1, 4, 31 on 3 consecutive cycles; remaining 3, 2, 1; lane_last only on 31.
  - Required: lane_valid=0 on the 4th cycle.
- Backpressure: mask 32'h0000_0005 with lane_ready low 3 cycles on lane 0. Required: lane_id=0 and remaining=2 are held stable, then 0 and 2 are emitted, and mask_ready stays 0 until lane 2's handshake.
- Back-to-back: 32'h0000_0001 followed by 32'hC000_0000 held valid. Required: lane 0, then lane 30 on the very next cycle, then lane 31, with no bubble.
- Zero mask then full mask:
  - Stimulus: 32'h0, then 32'hFFFF_FFFF.
  - Required: the zero mask is accepted with no lane output.
  - Required: the full mask gives lane_ids 0..31 over 32 cycles, with remaining starting at 32.
- Mid-operation reset: assert rst after 2 lanes of 32'h0000_00FF. Required: next cycle is IDLE with remaining=0, and a fresh mask 32'h10 then yields only lane 4.
